// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared types and constants for the PS/2 scan-code receiver.
//   - ps2_state_e    : frame FSM states
//   - PS2_PREFIX_EXT : extended-key prefix byte (E0)
//   - PS2_PREFIX_BRK : break (key release) prefix byte (F0)
//   - PS2_EVENT_W    : width of one FIFO event {ext, brk, code[7:0]}
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam int         PS2_EVENT_W    = 10;

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo
//   Synchronous first-word-fall-through FIFO for decoded key events.
//   Ports:
//     clk_i, rst_i   : clock, synchronous active-high reset (pointers only)
//     push_i         : write request; accepted when not full, or when full
//                      and a pop happens in the same cycle
//     push_data_i    : entry to write
//     pop_i          : remove head entry (ignored when empty)
//     full_o/empty_o : occupancy flags
//     head_o         : entry at the head, valid while empty_o is low
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // When full, the slot being written is the head being popped this cycle;
    // the head is read combinationally so the old value is consumed first.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
//   PS/2 keyboard receiver in the system clock domain: synchronises and
//   filters the PS/2 lines, frames bytes (start, 8 data LSB first, odd
//   parity, stop), applies an inactivity timeout, folds E0/F0 prefixes into
//   single events, buffers them in a FIFO and tracks held keys.
//   Ports:
//     CLK, RESET        : system clock, synchronous active-high reset
//     PS2_CLK, PS2_DAT  : raw asynchronous PS/2 pins
//     CODE/EXTENDED/BREAK : head event fields, valid while VALID
//     VALID, READY      : read handshake; pop on VALID && READY
//     FRAME_ERR         : one-cycle pulse on parity/stop/timeout error
//     OVERFLOW          : sticky, an event was dropped on a full FIFO
//     KEY_DOWN          : held level per tracked key slot
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int                      FILTER_LEN     = 4,
    parameter int                      TIMEOUT_CYCLES = 100000,
    parameter int                      FIFO_DEPTH     = 8,
    parameter int                      NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*8-1:0]   KEY_CODES      = {8'h1B, 8'h1D, 8'h29, 8'h76}
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                PS2_CLK,
    input  logic                PS2_DAT,
    output logic [7:0]          CODE,
    output logic                EXTENDED,
    output logic                BREAK,
    output logic                VALID,
    input  logic                READY,
    output logic                FRAME_ERR,
    output logic                OVERFLOW,
    output logic [NUM_KEYS-1:0] KEY_DOWN
);

    localparam int            FW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

    // ---------------------------------------------------------------
    // Input synchronisers and PS2_CLK glitch filter
    // ---------------------------------------------------------------
    logic          clk_meta_q, clk_sync_q;
    logic          dat_meta_q, dat_sync_q;
    logic          clk_filt_q;
    logic [FW-1:0] flt_cnt_q;
    logic          strobe;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            clk_filt_q <= 1'b1;
            flt_cnt_q  <= '0;
        end else begin
            clk_meta_q <= PS2_CLK;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= PS2_DAT;
            dat_sync_q <= dat_meta_q;
            // Count consecutive samples that disagree with the filtered
            // level; any agreeing sample restarts the run.
            if (clk_sync_q == clk_filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FLT_LAST) begin
                clk_filt_q <= clk_sync_q;
                flt_cnt_q  <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + 1'b1;
            end
        end
    end

    // Strobe in the cycle where the filtered clock is about to fall.
    assign strobe = clk_filt_q && !clk_sync_q && (flt_cnt_q == FLT_LAST);

    // ---------------------------------------------------------------
    // Frame FSM with timeout; registered good-byte and error outputs
    // ---------------------------------------------------------------
    ps2_state_e  state_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        parity_q;
    logic [TW-1:0] to_cnt_q;
    logic        byte_vld_q;
    logic [7:0]  byte_q;
    logic        frame_err_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            to_cnt_q    <= '0;
            byte_vld_q  <= 1'b0;
            byte_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (state_q == ST_IDLE || strobe) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end

            if (state_q != ST_IDLE && !strobe && to_cnt_q == TO_LIMIT) begin
                state_q     <= ST_IDLE;
                frame_err_q <= 1'b1;
            end else if (strobe) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!dat_sync_q) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {dat_sync_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_q <= dat_sync_q;
                        state_q  <= ST_STOP;
                    end
                    ST_STOP: begin
                        // Odd parity: data ones plus parity bit must be odd.
                        if (dat_sync_q && (^{shift_q, parity_q})) begin
                            byte_vld_q <= 1'b1;
                            byte_q     <= shift_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign FRAME_ERR = frame_err_q;

    // ---------------------------------------------------------------
    // Prefix decoder, event FIFO push, key table
    // ---------------------------------------------------------------
    logic                   ext_q, ext_d;
    logic                   brk_q, brk_d;
    logic                   ovf_q, ovf_d;
    logic [NUM_KEYS-1:0]    key_down_q, key_down_d;
    logic                   emit;
    logic [PS2_EVENT_W-1:0] evt;
    logic [PS2_EVENT_W-1:0] head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;

    assign emit = byte_vld_q && (byte_q != PS2_PREFIX_EXT) && (byte_q != PS2_PREFIX_BRK);
    assign evt  = {ext_q, brk_q, byte_q};
    assign pop  = !fifo_empty && READY;

    always_comb begin
        ext_d      = ext_q;
        brk_d      = brk_q;
        ovf_d      = ovf_q;
        key_down_d = key_down_q;
        if (frame_err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_vld_q) begin
            if (byte_q == PS2_PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (byte_q == PS2_PREFIX_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (fifo_full && !pop) begin
                    ovf_d = 1'b1;
                end
                // Key levels follow every emitted non-extended event,
                // whether or not the FIFO could accept it.
                if (!ext_q) begin
                    for (int i = 0; i < NUM_KEYS; i++) begin
                        if (byte_q == KEY_CODES[8*i +: 8]) begin
                            key_down_d[i] = !brk_q;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            ovf_q      <= 1'b0;
            key_down_q <= '0;
        end else begin
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            ovf_q      <= ovf_d;
            key_down_q <= key_down_d;
        end
    end

    ps2_event_fifo #(
        .WIDTH (PS2_EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .push_i      (emit),
        .push_data_i (evt),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (head)
    );

    // Head fields read as zero while empty so outputs are clean out of reset.
    assign VALID    = !fifo_empty;
    assign CODE     = fifo_empty ? 8'h00 : head[7:0];
    assign BREAK    = !fifo_empty && head[8];
    assign EXTENDED = !fifo_empty && head[9];
    assign OVERFLOW = ovf_q;
    assign KEY_DOWN = key_down_q;

endmodule
